// File: rtl/mat_loader.sv
// Operand feeder for mat_mult: streams E elements into mat1 then mat2 (row-major), holds
// enable_mult until mult_done, reports completion on done/ack and flags a MULT-phase timeout.
module mat_loader #(
  parameter int N_ROWS         = 2,
  parameter int N_COLUMNS      = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] in_data,
  output logic signed [31:0] mat1 [N_ROWS][N_COLUMNS],
  output logic signed [31:0] mat2 [N_ROWS][N_COLUMNS],
  output logic               enable_mult,
  input  logic               mult_done,
  output logic               done,
  input  logic               ack,
  output logic               err_timeout,
  output logic               busy
);

  localparam int E      = N_ROWS * N_COLUMNS;
  localparam int IDX_W  = $clog2(E) + 1;
  localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(E - 1);
  localparam logic [TCNT_W-1:0] LAST_T   = TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    MULT,
    DONE
  } state_t;

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [TCNT_W-1:0]   tcnt, tcnt_nxt;
  logic                mult_first, mult_first_nxt;
  logic                err_nxt;
  logic                wr_a, wr_b;

  // mult_first marks the first MULT cycle, where a stale mult_done from the previous run is ignored.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_nxt      = state;
    idx_nxt        = idx;
    tcnt_nxt       = tcnt;
    mult_first_nxt = 1'b0;
    err_nxt        = err_timeout;
    in_ready       = 1'b0;
    enable_mult    = 1'b0;
    done           = 1'b0;
    wr_a           = 1'b0;
    wr_b           = 1'b0;

    unique case (state)
      IDLE, LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_a = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt   = '0;
            state_nxt = LOAD_B;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = LOAD_A;
          end
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid) begin
          wr_b = 1'b1;
          if (idx == LAST_IDX) begin
            idx_nxt        = '0;
            tcnt_nxt       = '0;
            mult_first_nxt = 1'b1;
            state_nxt      = MULT;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      MULT: begin
        enable_mult = 1'b1;
        tcnt_nxt    = tcnt + 1'b1;
        if (!mult_first && mult_done) begin
          state_nxt = DONE;
        end else if (TIMEOUT_CYCLES != 0 && tcnt == LAST_T && !mult_done) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        enable_mult = 1'b1;
        done        = 1'b1;
        if (ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (reset) in_ready = 1'b0;

    // clear wins over everything, including a beat accepted in the same cycle.
    if (clear) begin
      state_nxt      = IDLE;
      idx_nxt        = '0;
      tcnt_nxt       = '0;
      mult_first_nxt = 1'b0;
      err_nxt        = 1'b0;
      wr_a           = 1'b0;
      wr_b           = 1'b0;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      tcnt        <= '0;
      mult_first  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state       <= state_nxt;
      idx         <= idx_nxt;
      tcnt        <= tcnt_nxt;
      mult_first  <= mult_first_nxt;
      err_timeout <= err_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the banks are reset on purpose so a load cut short by reset reads back as all zeros.
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLUMNS; c++) begin
          mat1[r][c] <= '0;
          mat2[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < N_COLUMNS; c++) begin
          if (wr_a && idx == IDX_W'(r * N_COLUMNS + c)) mat1[r][c] <= in_data;
          if (wr_b && idx == IDX_W'(r * N_COLUMNS + c)) mat2[r][c] <= in_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_loader.sv
// Randomised bench for mat_loader: a transaction-level model (beat count, MULT cycle count,
// done/error flags) predicts every output on each falling edge; literal checks pin the model.
module tb_mat_loader;

  localparam int NR = 2;
  localparam int NC = 2;
  localparam int T  = 8;
  localparam int E  = NR * NC;

  logic               clk       = 1'b0;
  logic               reset     = 1'b0;
  logic               clear     = 1'b0;
  logic               in_valid  = 1'b0;
  logic               mult_done = 1'b0;
  logic               ack       = 1'b0;
  logic signed [31:0] in_data   = '0;
  logic               in_ready, enable_mult, done, err_timeout, busy;
  logic signed [31:0] mat1 [NR][NC];
  logic signed [31:0] mat2 [NR][NC];

  int n_tests = 0;
  int n_fail  = 0;

  mat_loader #(.N_ROWS(NR), .N_COLUMNS(NC), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mat1(mat1), .mat2(mat2),
    .enable_mult(enable_mult), .mult_done(mult_done),
    .done(done), .ack(ack), .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_a [E];
  int m_b [E];
  int m_beats   = 0;   // beats accepted in the current load (0..2E-1)
  int m_mcyc    = 0;   // 0 when not multiplying, else 1-based MULT cycle number
  bit m_done_ph = 1'b0;
  bit m_err     = 1'b0;

  initial begin
    for (int i = 0; i < E; i++) begin
      m_a[i] = 0;
      m_b[i] = 0;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < E; i++) begin
        m_a[i] = 0;
        m_b[i] = 0;
      end
      m_beats = 0; m_mcyc = 0; m_done_ph = 1'b0; m_err = 1'b0;
    end else if (clear) begin
      m_beats = 0; m_mcyc = 0; m_done_ph = 1'b0; m_err = 1'b0;
    end else if (m_done_ph) begin
      if (ack) m_done_ph = 1'b0;
    end else if (m_mcyc != 0) begin
      if (m_mcyc >= 2 && mult_done) begin
        m_done_ph = 1'b1;
        m_mcyc    = 0;
      end else if (T != 0 && m_mcyc == T && !mult_done) begin
        m_err  = 1'b1;
        m_mcyc = 0;
      end else begin
        m_mcyc++;
      end
    end else if (in_valid) begin
      if (m_beats < E) m_a[m_beats] = in_data;
      else             m_b[m_beats - E] = in_data;
      m_beats++;
      if (m_beats == 2 * E) begin
        m_beats = 0;
        m_mcyc  = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("in_ready",    in_ready,    !reset && m_mcyc == 0 && !m_done_ph);
    check("enable_mult", enable_mult, m_mcyc != 0 || m_done_ph);
    check("done",        done,        m_done_ph);
    check("busy",        busy,        m_beats != 0 || m_mcyc != 0 || m_done_ph);
    check("err_timeout", err_timeout, m_err);
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        check($sformatf("mat1[%0d][%0d]", r, c), mat1[r][c], m_a[r * NC + c]);
        check($sformatf("mat2[%0d][%0d]", r, c), mat2[r][c], m_b[r * NC + c]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: valid held high, 1: valid toggles 1/0, 2: random gaps
  task automatic send(input int vals[$], input int mode);
    int  i = 0;
    int  guard = 0;
    bit  acc;
    while (i < vals.size()) begin
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = ~in_valid;
        default: in_valid = 1'($urandom_range(1));
      endcase
      in_data = in_valid ? vals[i] : $urandom;
      acc = in_valid && in_ready;
      tick();
      if (acc) i++;
      guard++;
      if (guard > 200) begin
        check("send_budget", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_mult(input int delay, input int ack_wait);
    int guard = 0;
    for (int c = 0; c < delay && busy && !done; c++) begin
      mult_done = 1'b0;
      tick();
    end
    mult_done = 1'b1;
    while (!done && busy) begin
      tick();
      guard++;
      if (guard > 50) begin
        check("done_budget", 0, 1);
        break;
      end
    end
    mult_done = 1'b0;
    if (done) begin
      repeat (ack_wait) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
  endtask

  function automatic void fill_seq(output int q[$], input int start, input int step);
    q = {};
    for (int i = 0; i < 2 * E; i++) q.push_back(start + i * step);
  endfunction

  function automatic void fill_rand(output int q[$]);
    q = {};
    for (int i = 0; i < 2 * E; i++) q.push_back(int'($urandom));
  endfunction

  task automatic check_banks(input string tag, input int base, input int step);
    for (int k = 0; k < E; k++) begin
      check($sformatf("%s mat1[%0d]", tag, k), mat1[k / NC][k % NC], base + k * step);
      check($sformatf("%s mat2[%0d]", tag, k), mat2[k / NC][k % NC], base + (E + k) * step);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];

    // reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 0);
    check("rst busy", busy, 0);
    check("rst mat1[0][0]", mat1[0][0], 0);
    reset = 1'b0;
    tick();

    // 1: contiguous load 1..8, mult_done 3 cycles after enable
    fill_seq(q, 1, 1);
    send(q, 0);
    check("t1 enable latency", enable_mult, 1);
    check("t1 in_ready in MULT", in_ready, 0);
    check_banks("t1", 1, 1);
    check("t1 model pin m_a[3]", m_a[3], 4);
    check("t1 model pin m_b[0]", m_b[0], 5);
    run_mult(3, 1);
    check("t1 done released", done, 0);
    check("t1 busy idle", busy, 0);

    // 2: gappy stream, same data
    send(q, 1);
    check_banks("t2", 1, 1);
    run_mult(2, 0);

    // 3: stale mult_done held high through the load
    mult_done = 1'b1;
    fill_rand(q);
    send(q, 0);
    check("t3 cycle1 done", done, 0);
    check("t3 cycle1 enable", enable_mult, 1);
    tick();
    check("t3 cycle2 done", done, 0);
    tick();
    check("t3 cycle3 done", done, 1);
    mult_done = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("t3 idle", busy, 0);

    // 4: timeout after T MULT cycles, reload works, clear drops the flag
    fill_rand(q);
    send(q, 0);
    repeat (T - 1) tick();
    check("t4 last MULT enable", enable_mult, 1);
    check("t4 last MULT err", err_timeout, 0);
    tick();
    check("t4 err set", err_timeout, 1);
    check("t4 idle", busy, 0);
    check("t4 enable low", enable_mult, 0);
    fill_rand(q);
    send(q, 2);
    run_mult(1, 0);
    check("t4 err sticky", err_timeout, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t4 err cleared", err_timeout, 0);

    // 5: clear on the 3rd B beat, then reload -1..-8
    fill_seq(q, 100, 1);
    q = q[0:E + 1];
    send(q, 0);
    in_valid = 1'b1;
    in_data  = 999;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("t5 idle after clear", busy, 0);
    check("t5 ready after clear", in_ready, 1);
    fill_seq(q, -1, -1);
    send(q, 0);
    check_banks("t5", -1, -1);
    run_mult(1, 2);

    // 6: async reset between edges during MULT
    fill_rand(q);
    send(q, 0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("t6 enable fell", enable_mult, 0);
    check("t6 done low", done, 0);
    check("t6 busy fell", busy, 0);
    check_banks("t6", 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();

    // randomised runs
    repeat (30) begin
      mult_done = 1'($urandom_range(1));
      fill_rand(q);
      send(q, 2);
      run_mult($urandom_range(0, 10), $urandom_range(0, 3));
      ack       = 1'($urandom_range(1));
      mult_done = 1'($urandom_range(1));
      clear     = ($urandom_range(3) == 0);
      tick();
      ack = 1'b0; mult_done = 1'b0; clear = 1'b0;
    end

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
